// File: rtl/relay_frame_ctrl.sv
// Relay-link framing controller: frame start/end detection, front-end mode drive,
// relay bit gating and a nibble capture FIFO that is drained serially in debug mode.
module relay_frame_ctrl #(
    parameter int          FIFO_DEPTH   = 32,
    parameter int          HIST_NIB     = 5,
    parameter int          END_NIBS     = 3,
    parameter logic [3:0]  READER_START = 4'hC,
    parameter logic [3:0]  TAG_START    = 4'hF,
    parameter int          PRE_TIMEOUT  = 4096,
    parameter int          SSP_DIV      = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [2:0]                    hi_simulate_mod_type,
    input  logic                          data_in,
    input  logic [3:0]                    nib_in,
    input  logic                          nib_valid,
    input  logic                          relay_raw,
    output logic                          relay_gated,
    output logic [2:0]                    mod_type,
    output logic                          ssp_din,
    output logic [7:0]                    frame_count,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int HW = 4 * HIST_NIB;
    localparam int PW = $clog2(PRE_TIMEOUT) + 1;
    localparam int DW = $clog2(SSP_DIV) + 1;

    typedef enum logic [1:0] {ST_OFF, ST_LISTEN, ST_PRE, ST_MOD} state_t;

    state_t          state, state_n;
    logic [2:0]      role_q;
    logic [2:0]      mod_n;
    logic [HW-1:0]   hist, hist_shift;
    logic [7:0]      nib_count, cnt_inc;
    logic [PW-1:0]   pre_cnt;
    logic [3:0]      start_nib;
    logic            is_reader, is_tag, is_fake, is_debug, role_chg;
    logic            start_match, end_match;

    logic [3:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [DW-1:0]   div_cnt;
    logic [1:0]      bit_idx;
    logic            push, full;

    assign is_reader   = (hi_simulate_mod_type == 3'b101);
    assign is_tag      = (hi_simulate_mod_type == 3'b110);
    assign is_debug    = (hi_simulate_mod_type == 3'b111);
    assign is_fake     = is_reader | is_tag;
    assign role_chg    = (hi_simulate_mod_type != role_q);
    assign start_nib   = is_reader ? READER_START : TAG_START;
    assign hist_shift  = {hist[HW-5:0], nib_in};
    assign cnt_inc     = (nib_count == '1) ? nib_count : nib_count + 8'd1;
    assign start_match = nib_valid && (hist_shift == {{(HW-4){1'b0}}, start_nib});
    // Frame closes only on a byte boundary after enough trailing zero nibbles.
    assign end_match   = nib_valid && (hist_shift[4*END_NIBS-1:0] == '0)
                         && (cnt_inc >= 8'(END_NIBS)) && !cnt_inc[0];
    assign relay_gated = relay_raw & (state != ST_MOD);

    always_comb begin
        state_n = state;
        if (!is_fake)
            state_n = ST_OFF;
        else if (role_chg)
            state_n = ST_LISTEN;
        else begin
            case (state)
                ST_OFF:    state_n = ST_LISTEN;
                ST_LISTEN: if (start_match) state_n = ST_MOD;
                           else if (data_in) state_n = ST_PRE;
                ST_PRE:    if (start_match) state_n = ST_MOD;
                           else if (pre_cnt == PW'(PRE_TIMEOUT - 1)) state_n = ST_LISTEN;
                ST_MOD:    if (end_match) state_n = ST_LISTEN;
                default:   state_n = ST_OFF;
            endcase
        end
    end

    always_comb begin
        mod_n = 3'b000;
        case (state_n)
            ST_LISTEN: mod_n = is_reader ? 3'b011 : 3'b001;
            ST_MOD:    mod_n = is_reader ? 3'b100 : 3'b010;
            default:   mod_n = 3'b000;
        endcase
        if (is_debug)
            mod_n = 3'b011;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_OFF;
            role_q      <= '0;
            mod_type    <= '0;
            hist        <= '0;
            nib_count   <= '0;
            pre_cnt     <= '0;
            frame_count <= '0;
        end else begin
            role_q   <= hi_simulate_mod_type;
            state    <= state_n;
            mod_type <= mod_n;
            pre_cnt  <= (state == ST_PRE && state_n == ST_PRE) ? pre_cnt + 1'b1 : '0;
            if (!is_fake || role_chg) begin
                hist      <= '0;
                nib_count <= '0;
            end else begin
                if (nib_valid)
                    hist <= hist_shift;
                if (state != ST_MOD && state_n == ST_MOD)
                    nib_count <= '0;
                else if (state == ST_MOD && nib_valid)
                    nib_count <= cnt_inc;
                if (state == ST_MOD && state_n == ST_LISTEN)
                    frame_count <= frame_count + 8'd1;
            end
        end
    end

    assign push = is_fake && nib_valid;
    assign full = (fifo_level == (AW+1)'(FIFO_DEPTH));

    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr] <= nib_in;
    end

    // Push happens only in FAKE roles and pop only in DEBUG, so they never coincide.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            overflow   <= 1'b0;
            ssp_din    <= 1'b0;
            div_cnt    <= '0;
            bit_idx    <= '0;
        end else begin
            if (push) begin
                if (full) begin
                    overflow <= 1'b1;
                end else begin
                    wr_ptr     <= wr_ptr + 1'b1;
                    fifo_level <= fifo_level + 1'b1;
                end
            end
            if (is_debug && fifo_level != '0) begin
                ssp_din <= mem[rd_ptr][~bit_idx];
                if (div_cnt == DW'(SSP_DIV - 1)) begin
                    div_cnt <= '0;
                    bit_idx <= bit_idx + 2'd1;
                    if (bit_idx == 2'd3) begin
                        rd_ptr     <= rd_ptr + 1'b1;
                        fifo_level <= fifo_level - 1'b1;
                    end
                end else begin
                    div_cnt <= div_cnt + 1'b1;
                end
            end else begin
                ssp_din <= 1'b0;
                if (!is_debug) begin
                    div_cnt <= '0;
                    bit_idx <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_relay_frame_ctrl.sv
// Directed self-checking bench for relay_frame_ctrl with hand-computed expectations.
module tb_relay_frame_ctrl;
    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] hi_simulate_mod_type;
    logic       data_in;
    logic [3:0] nib_in;
    logic       nib_valid;
    logic       relay_raw;
    logic       relay_gated;
    logic [2:0] mod_type;
    logic       ssp_din;
    logic [7:0] frame_count;
    logic       overflow;
    logic [5:0] fifo_level;

    int tests = 0;
    int fails = 0;

    relay_frame_ctrl #(
        .FIFO_DEPTH(32), .HIST_NIB(5), .END_NIBS(3),
        .READER_START(4'hC), .TAG_START(4'hF),
        .PRE_TIMEOUT(4096), .SSP_DIV(16)
    ) dut (
        .clk(clk), .reset(reset), .hi_simulate_mod_type(hi_simulate_mod_type),
        .data_in(data_in), .nib_in(nib_in), .nib_valid(nib_valid),
        .relay_raw(relay_raw), .relay_gated(relay_gated), .mod_type(mod_type),
        .ssp_din(ssp_din), .frame_count(frame_count), .overflow(overflow),
        .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_nib(input logic [3:0] n);
        nib_in    = n;
        nib_valid = 1'b1;
        tick();
        nib_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; hi_simulate_mod_type = 3'b000; data_in = 1'b0;
        nib_in = '0; nib_valid = 1'b0; relay_raw = 1'b1;
        tick(); tick();
        check("rst_mod", 32'(mod_type), 32'h0);
        check("rst_ssp", 32'(ssp_din), 32'h0);
        check("rst_frames", 32'(frame_count), 32'h0);
        check("rst_ovf", 32'(overflow), 32'h0);
        check("rst_level", 32'(fifo_level), 32'h0);
        reset = 1'b0;

        // Reader frame: start on C, close after 1,2,0,0,0,0
        hi_simulate_mod_type = 3'b101;
        tick();
        check("rd_listen", 32'(mod_type), 32'h3);
        send_nib(4'h0); send_nib(4'h0); send_nib(4'h0); send_nib(4'h0);
        check("rd_pre_c", 32'(mod_type), 32'h3);
        send_nib(4'hC);
        check("rd_mod", 32'(mod_type), 32'h4);
        check("rd_gated", 32'(relay_gated), 32'h0);
        send_nib(4'h1); send_nib(4'h2); send_nib(4'h0); send_nib(4'h0); send_nib(4'h0);
        check("rd_cnt5", 32'(mod_type), 32'h4);
        send_nib(4'h0);
        check("rd_end", 32'(mod_type), 32'h3);
        check("rd_frames1", 32'(frame_count), 32'h1);
        check("rd_gated_l", 32'(relay_gated), 32'h1);

        // Odd count with trailing zeros holds MOD until even
        send_nib(4'h0); send_nib(4'h0); send_nib(4'h0); send_nib(4'h0); send_nib(4'hC);
        check("odd_mod", 32'(mod_type), 32'h4);
        send_nib(4'h5); send_nib(4'h5); send_nib(4'h0); send_nib(4'h0); send_nib(4'h0);
        check("odd_hold", 32'(mod_type), 32'h4);
        send_nib(4'h0);
        check("odd_end", 32'(mod_type), 32'h3);
        check("odd_frames2", 32'(frame_count), 32'h2);

        // Role change while in MOD
        send_nib(4'h0); send_nib(4'h0); send_nib(4'h0); send_nib(4'h0); send_nib(4'hC);
        check("rc_mod", 32'(mod_type), 32'h4);
        hi_simulate_mod_type = 3'b110;
        tick();
        check("rc_tag_listen", 32'(mod_type), 32'h1);
        check("rc_frames", 32'(frame_count), 32'h2);

        // Tag: PRE entry, timeout, start wins over data_in
        data_in = 1'b1;
        tick();
        check("tag_pre", 32'(mod_type), 32'h0);
        data_in = 1'b0;
        repeat (4095) tick();
        check("tag_pre_hold", 32'(mod_type), 32'h0);
        tick();
        check("tag_timeout", 32'(mod_type), 32'h1);
        send_nib(4'h0); send_nib(4'h0); send_nib(4'h0); send_nib(4'h0);
        data_in = 1'b1;
        send_nib(4'hF);
        data_in = 1'b0;
        check("tag_mod", 32'(mod_type), 32'h2);
        check("fifo_32", 32'(fifo_level), 32'd32);
        check("fifo_no_ovf", 32'(overflow), 32'h0);

        // Reset in MOD
        reset = 1'b1;
        tick();
        check("rstm_mod", 32'(mod_type), 32'h0);
        check("rstm_frames", 32'(frame_count), 32'h0);
        check("rstm_level", 32'(fifo_level), 32'h0);
        reset = 1'b0;
        tick();
        check("rstm_relisten", 32'(mod_type), 32'h1);

        // FIFO fill and overflow
        send_nib(4'hA); send_nib(4'h5);
        repeat (30) send_nib(4'h1);
        check("ff_level32", 32'(fifo_level), 32'd32);
        check("ff_ovf0", 32'(overflow), 32'h0);
        send_nib(4'h1);
        check("ff_level_full", 32'(fifo_level), 32'd32);
        check("ff_ovf1", 32'(overflow), 32'h1);

        // DEBUG readout of 4'hA = 1010, MSB first, 16 clks per bit
        hi_simulate_mod_type = 3'b111;
        tick();
        check("dbg_mod", 32'(mod_type), 32'h3);
        check("dbg_b3_first", 32'(ssp_din), 32'h1);
        repeat (15) tick();
        check("dbg_b3_last", 32'(ssp_din), 32'h1);
        tick();
        check("dbg_b2", 32'(ssp_din), 32'h0);
        repeat (16) tick();
        check("dbg_b1", 32'(ssp_din), 32'h1);
        repeat (16) tick();
        check("dbg_b0", 32'(ssp_din), 32'h0);
        repeat (14) tick();
        check("dbg_level_pre_pop", 32'(fifo_level), 32'd32);
        tick();
        check("dbg_level_pop", 32'(fifo_level), 32'd31);
        tick();
        check("dbg_n2_b3", 32'(ssp_din), 32'h0);
        repeat (16) tick();
        check("dbg_n2_b2", 32'(ssp_din), 32'h1);
        repeat (47) tick();
        check("dbg_level_pop2", 32'(fifo_level), 32'd30);

        // Reset mid-readout
        repeat (5) tick();
        reset = 1'b1;
        tick();
        check("rstd_mod", 32'(mod_type), 32'h0);
        check("rstd_ssp", 32'(ssp_din), 32'h0);
        check("rstd_level", 32'(fifo_level), 32'h0);
        check("rstd_ovf", 32'(overflow), 32'h0);
        reset = 1'b0;
        tick(); tick();
        check("dbg_empty_mod", 32'(mod_type), 32'h3);
        check("dbg_empty_ssp", 32'(ssp_din), 32'h0);
        check("dbg_empty_level", 32'(fifo_level), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
